// File: rtl/gpio_mmio_bank_if.sv
// gpio_mmio_bank_if
//  CPU data-bus bundle for the GPIO MMIO bank.
//  Signals:
//   en       write strobe, one write per asserted cycle
//   address  bit/word address
//   dataIn   write data; [0]=value, [2:1]=write op
//   dataOut  registered read data (driven by the bank)
//  Modports: master (CPU side), slave (bank side).
interface gpio_mmio_bank_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic              en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;

    modport master (output en, output address, output dataIn, input dataOut);
    modport slave  (input en, input address, input dataIn, output dataOut);
endinterface

// File: rtl/gpio_mmio_bank.sv
// gpio_mmio_bank
//  Bit-addressed memory-mapped I/O bank: R/W output bits (gpio2), synchronised
//  read-only input bits (gpio1), a switch word, per-input rising-edge sticky
//  flags with an interrupt line, atomic set/clear/toggle writes and a
//  registered read port with one cycle of latency.
//  Optional feature macro: GPIO_MMIO_DEBOUNCE_EN (switch debouncing).
//  Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       slave side of gpio_mmio_bank_if (en, address, dataIn, dataOut)
//   switches  asynchronous board switches
//   gpio1     asynchronous GPIO inputs
//   gpio2     registered GPIO outputs
//   irq       registered interrupt request
//  Address map: outputs 0..N_OUT-1, inputs next N_IN, switch word, N_IN edge
//  flags, then irq enable. Anything above irq enable reads 0, writes ignored.
module gpio_mmio_bank #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 24,
    parameter int N_OUT   = 36,
    parameter int N_IN    = 35,
    parameter int N_SW    = 4,
    parameter int SYNC_ST = 2,
    parameter int DEB_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_mmio_bank_if.slave      bus,
    input  logic [N_SW-1:0]      switches,
    input  logic [N_IN-1:0]      gpio1,
    output logic [N_OUT-1:0]     gpio2,
    output logic                 irq
);
    localparam int A_SW_I    = N_OUT + N_IN;
    localparam int A_EDG_I   = A_SW_I + 1;
    localparam int A_IRQEN_I = A_SW_I + N_IN + 1;
    localparam logic [ADDR_W-1:0] A_SW    = ADDR_W'(A_SW_I);
    localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(A_IRQEN_I);

    logic [N_IN-1:0]   in_sync_q [SYNC_ST];
    logic [N_SW-1:0]   sw_sync_q [SYNC_ST];
    logic [N_OUT-1:0]  gpio2_q, gpio2_d;
    logic [N_IN-1:0]   edge_q, edge_d, rise;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [N_SW-1:0]   sw_val;
    logic [1:0]        op;
    logic              unused_bits;

    assign op          = bus.dataIn[2:1];
    assign unused_bits = ^bus.dataIn[DATA_W-1:3];

    // A rising edge is seen when the second-to-last stage holds 1 while the
    // last stage still holds 0; the flag then sets together with the
    // synchronised value going high.
    assign rise = in_sync_q[SYNC_ST-2] & ~in_sync_q[SYNC_ST-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            logic sel;
            assign sel = bus.en && (bus.address == ADDR_W'(gi));
            assign gpio2_d[gi] = !sel            ? gpio2_q[gi]    :
                                 (op == 2'b00)   ? bus.dataIn[0]  :
                                 (op == 2'b01)   ? 1'b1           :
                                 (op == 2'b10)   ? 1'b0           :
                                                   ~gpio2_q[gi];
        end
        // A clear coinciding with a fresh edge leaves the flag set.
        for (gi = 0; gi < N_IN; gi++) begin : g_edge
            logic clr;
            assign clr = bus.en && (bus.address == ADDR_W'(A_EDG_I + gi));
            assign edge_d[gi] = (edge_q[gi] & ~clr) | rise[gi];
        end
    endgenerate

    assign irq_en_d = (bus.en && bus.address == A_IRQEN) ? bus.dataIn[0] : irq_en_q;
    assign irq_d    = irq_en_q & (|edge_q);

`ifdef GPIO_MMIO_DEBOUNCE_EN
    // Each switch keeps a stable value that only follows the synchronised
    // input after it has disagreed for DEB_CYC consecutive cycles.
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    logic [N_SW-1:0]  deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_deb
            logic differ, done;
            assign differ    = sw_sync_q[SYNC_ST-1][gi] ^ deb_q[gi];
            assign done      = differ && (cnt_q[gi] == CNT_W'(DEB_CYC - 1));
            assign deb_d[gi] = done ? sw_sync_q[SYNC_ST-1][gi] : deb_q[gi];
            assign cnt_d[gi] = (differ && !done) ? cnt_q[gi] + 1'b1 : '0;
        end
    endgenerate
    assign sw_val = deb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < N_SW; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    assign sw_val = sw_sync_q[SYNC_ST-1];
`endif

    // Read mux sees pre-write state, so a same-cycle write is not reflected.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < N_OUT; i++)
            if (bus.address == ADDR_W'(i)) rd_d[0] = gpio2_q[i];
        for (int i = 0; i < N_IN; i++)
            if (bus.address == ADDR_W'(N_OUT + i)) rd_d[0] = in_sync_q[SYNC_ST-1][i];
        if (bus.address == A_SW) rd_d[N_SW-1:0] = sw_val;
        for (int i = 0; i < N_IN; i++)
            if (bus.address == ADDR_W'(A_EDG_I + i)) rd_d[0] = edge_q[i];
        if (bus.address == A_IRQEN) rd_d[0] = irq_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_ST; i++) begin
                in_sync_q[i] <= '0;
                sw_sync_q[i] <= '0;
            end
            gpio2_q  <= '0;
            edge_q   <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            in_sync_q[0] <= gpio1;
            sw_sync_q[0] <= switches;
            for (int i = 1; i < SYNC_ST; i++) begin
                in_sync_q[i] <= in_sync_q[i-1];
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
            gpio2_q  <= gpio2_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rd_q     <= rd_d;
        end
    end

    assign gpio2       = gpio2_q;
    assign irq         = irq_q;
    assign bus.dataOut = rd_q;
endmodule

// File: tb/tb_gpio_mmio_bank.sv
// tb_gpio_mmio_bank
//  Directed and randomised stimulus for gpio_mmio_bank, compared every cycle
//  against a transaction-level reference model (delay-line inputs, bit-mask
//  register state).
module tb_gpio_mmio_bank;
    localparam int ADDR_W = 8, DATA_W = 24, N_OUT = 36, N_IN = 35, N_SW = 4;
    localparam int SYNC_ST = 2, DEB_CYC = 16;
    localparam int A_SW = N_OUT + N_IN, A_EDG = A_SW + 1, A_IRQEN = A_SW + N_IN + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_SW-1:0]   switches = '0;
    logic [N_IN-1:0]   gpio1 = '0;
    logic [N_OUT-1:0]  gpio2;
    logic              irq;

    gpio_mmio_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gpio_mmio_bank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN),
        .N_SW(N_SW), .SYNC_ST(SYNC_ST), .DEB_CYC(DEB_CYC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .switches(switches),
        .gpio1(gpio1), .gpio2(gpio2), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [N_OUT-1:0]  m_out;
    logic [N_IN-1:0]   m_flag, m_sync;
    logic [N_SW-1:0]   m_sw;
    logic              m_irqen, m_irq;
    logic [DATA_W-1:0] m_rd;
    logic [N_IN-1:0]   gq[$];
    logic [N_SW-1:0]   sq[$];

    task automatic model_reset();
        m_out = '0; m_flag = '0; m_sync = '0; m_sw = '0;
        m_irqen = 1'b0; m_irq = 1'b0; m_rd = '0;
        gq.delete(); sq.delete();
        repeat (SYNC_ST) begin gq.push_back('0); sq.push_back('0); end
    endtask

    function automatic logic [DATA_W-1:0] read_model(input int a);
        logic [DATA_W-1:0] r;
        logic [N_OUT-1:0]  t_out;
        logic [N_IN-1:0]   t_in;
        r = '0;
        if (a < N_OUT) begin
            t_out = m_out >> a; r[0] = t_out[0];
        end else if (a < N_OUT + N_IN) begin
            t_in = m_sync >> (a - N_OUT); r[0] = t_in[0];
        end else if (a == A_SW) begin
            r[N_SW-1:0] = m_sw;
        end else if (a <= A_SW + N_IN) begin
            t_in = m_flag >> (a - A_EDG); r[0] = t_in[0];
        end else if (a == A_IRQEN) begin
            r[0] = m_irqen;
        end
        return r;
    endfunction

    // One clock: predict from current inputs and model state, then compare.
    task automatic step(input string tag);
        logic [N_OUT-1:0]  n_out, mk;
        logic [N_IN-1:0]   n_flag, s_new, clr;
        logic [N_SW-1:0]   w_new;
        logic              n_irqen, n_irq;
        logic [DATA_W-1:0] n_rd;
        int                a;
        logic [1:0]        op;
        a  = int'(bus.address);
        op = bus.dataIn[2:1];
        gq.push_front(gpio1); sq.push_front(switches);
        s_new = gq[SYNC_ST-1]; w_new = sq[SYNC_ST-1];
        void'(gq.pop_back()); void'(sq.pop_back());
        n_rd = read_model(a);
        n_out = m_out; n_irqen = m_irqen; n_irq = m_irqen & (|m_flag); clr = '0;
        if (bus.en) begin
            if (a < N_OUT) begin
                mk = N_OUT'(1) << a;
                case (op)
                    2'b00: n_out = bus.dataIn[0] ? (m_out | mk) : (m_out & ~mk);
                    2'b01: n_out = m_out | mk;
                    2'b10: n_out = m_out & ~mk;
                    default: n_out = m_out ^ mk;
                endcase
            end else if (a >= A_EDG && a < A_EDG + N_IN) begin
                clr = N_IN'(1) << (a - A_EDG);
            end else if (a == A_IRQEN) begin
                n_irqen = bus.dataIn[0];
            end
        end
        n_flag = (m_flag & ~clr) | (s_new & ~m_sync);
        @(posedge clk); #1;
        if (rst) begin
            model_reset();
        end else begin
            m_out = n_out; m_flag = n_flag; m_sync = s_new; m_sw = w_new;
            m_irqen = n_irqen; m_irq = n_irq; m_rd = n_rd;
        end
        check({tag, "_gpio2"}, 64'(gpio2), 64'(m_out));
        check({tag, "_dout"}, 64'(bus.dataOut), 64'(m_rd));
        check({tag, "_irq"}, 64'(irq), 64'(m_irq));
    endtask

    task automatic cyc(input string tag, input logic e, input int a, input int d);
        bus.en = e; bus.address = ADDR_W'(a); bus.dataIn = DATA_W'(d);
        step(tag);
    endtask

    initial begin
        int k;
        bus.en = 1'b0; bus.address = '0; bus.dataIn = '0;
        model_reset();
        rst = 1'b1;
        cyc("rst0", 1'b0, 0, 0);
        cyc("rst1", 1'b1, 3, 3);
        check("rst_gpio2", 64'(gpio2), 64'd0);
        check("rst_dout", 64'(bus.dataOut), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;

        cyc("wr_after_rst", 1'b1, 0, 1);
        check("wr_after_rst_bit", 64'(gpio2[0]), 64'd1);

        cyc("op_set", 1'b1, 5, 3'b011);
        check("op_set_bit", 64'(gpio2[5]), 64'd1);
        cyc("op_clr", 1'b1, 5, 3'b101);
        check("op_clr_bit", 64'(gpio2[5]), 64'd0);
        cyc("op_tog", 1'b1, 5, 3'b111);
        check("op_tog_bit", 64'(gpio2[5]), 64'd1);

        // Edge flag and interrupt
        cyc("irqen", 1'b1, A_IRQEN, 1);
        gpio1[3] = 1'b1;
        k = 0;
        do begin cyc("edge_wait", 1'b0, A_EDG + 3, 0); k++; end while (!irq && k < 10);
        check("edge_irq_latency_ok", 64'(k <= SYNC_ST + 2), 64'd1);
        check("edge_flag_read", 64'(bus.dataOut), 64'd1);
        cyc("edge_clr", 1'b1, A_EDG + 3, 0);
        cyc("edge_after_clr", 1'b0, A_EDG + 3, 0);
        check("irq_low_after_clr", 64'(irq), 64'd0);

        // Clear coinciding with a new rising edge
        gpio1[3] = 1'b0; repeat (SYNC_ST + 2) cyc("race_a", 1'b0, A_EDG + 3, 0);
        gpio1[3] = 1'b1; repeat (SYNC_ST + 2) cyc("race_b", 1'b0, A_EDG + 3, 0);
        gpio1[3] = 1'b0; repeat (SYNC_ST + 2) cyc("race_c", 1'b0, A_EDG + 3, 0);
        gpio1[3] = 1'b1; repeat (SYNC_ST - 1) cyc("race_d", 1'b0, A_EDG + 3, 0);
        cyc("race_clr", 1'b1, A_EDG + 3, 0);
        check("race_irq_held", 64'(irq), 64'd1);
        cyc("race_read", 1'b0, A_EDG + 3, 0);
        check("race_flag_held", 64'(bus.dataOut), 64'd1);
        check("race_irq_still", 64'(irq), 64'd1);

`ifndef GPIO_MMIO_DEBOUNCE_EN
        switches = 4'hA;
        repeat (SYNC_ST + 1) cyc("sw_read", 1'b0, A_SW, 0);
        check("sw_word", 64'(bus.dataOut), 64'h00000A);
`endif
        cyc("oor_read", 1'b0, 200, 0);
        check("oor_read_zero", 64'(bus.dataOut), 64'd0);
        cyc("wr_in_ignored", 1'b1, 40, 7);
        cyc("wr_oor_ignored", 1'b1, 250, 7);

        rst = 1'b1;
        cyc("rst_mid", 1'b1, 7, 3);
        check("rst_mid_gpio2", 64'(gpio2), 64'd0);
        rst = 1'b0;

        // Randomised traffic
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) gpio1 = gpio1 ^ (N_IN'(1) << $urandom_range(0, N_IN - 1));
`ifndef GPIO_MMIO_DEBOUNCE_EN
            if ($urandom_range(0, 15) == 0) switches = N_SW'($urandom);
`endif
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0)
                cyc("rnd", 1'($urandom), $urandom_range(A_IRQEN + 1, 255), int'($urandom));
            else
                cyc("rnd", 1'($urandom), $urandom_range(0, A_IRQEN), int'($urandom));
        end
        rst = 1'b0;

`ifdef GPIO_MMIO_DEBOUNCE_EN
        bus.en = 1'b0; bus.address = ADDR_W'(A_SW);
        repeat (6) begin
            switches[0] = ~switches[0];
            repeat (5) @(posedge clk);
            #1;
        end
        check("deb_bounce_low", 64'(bus.dataOut[0]), 64'd0);
        switches[0] = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!bus.dataOut[0] && k < 100);
        check("deb_latency_min", 64'(k >= DEB_CYC), 64'd1);
        check("deb_latency_max", 64'(k <= DEB_CYC + SYNC_ST + 2), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
